// File: rtl/paged_mem_pkg.sv
// Shared types and helpers for the paged entry memory: writer states, log2 sizing, packed-slice indexing.
package paged_mem_pkg;

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_FREE = 1'b1
    } wr_state_t;

    // Ceiling log2, used to size address and page fields from depth parameters.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Low bit of page 'page' inside a flat vector of 'width'-bit slices.
    function automatic int slice_lo(input int page, input int width);
        return page * width;
    endfunction

endpackage

// File: rtl/paged_mem_bram.sv
// Simple dual-port block array with one write and one read port; the read port has an
// optional second output register selected by RD_LATENCY.
module paged_mem_bram
    import paged_mem_pkg::*;
#(
    parameter int RAM_WIDTH  = 18,
    parameter int DEPTH      = 128,
    parameter int RD_LATENCY = 2,
    localparam int ADDR_W    = clogb2(DEPTH)
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [RAM_WIDTH-1:0] wdata,
    input  logic                 re,
    input  logic                 rzero,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [RAM_WIDTH-1:0] dout
);

    logic [RAM_WIDTH-1:0] mem [DEPTH];
    logic [RAM_WIDTH-1:0] data_p1;

    always_ff @(posedge clka) begin
        if (we) mem[waddr] <= wdata;
    end

    // Stage 1: array read; rzero loads zero so out-of-range reads never expose stale words.
    always_ff @(posedge clka) begin
        if (rstb) begin
            data_p1 <= '0;
        end else if (re) begin
            data_p1 <= rzero ? '0 : mem[raddr];
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_reg2
            logic                 vld_p1;
            logic [RAM_WIDTH-1:0] data_p2;

            // Stage 2: output register, only advanced by a real read so rd_data holds otherwise.
            always_ff @(posedge clka) begin
                if (rstb) begin
                    vld_p1  <= 1'b0;
                    data_p2 <= '0;
                end else begin
                    vld_p1 <= re;
                    if (vld_p1) data_p2 <= data_p1;
                end
            end
            assign dout = data_p2;
        end else begin : g_reg1
            assign dout = data_p1;
        end
    endgenerate

endmodule

// File: rtl/paged_entry_memory.sv
// Multi-page hit/stub buffer: writer fills pages in order, reader accesses committed pages.
// Optional sticky overflow flags per page when PAGED_MEM_OVFL_EN is defined.
module paged_entry_memory
    import paged_mem_pkg::*;
#(
    parameter int RAM_WIDTH  = 18,
    parameter int PAGE_DEPTH = 32,
    parameter int NPAGES     = 4,
    parameter int RD_LATENCY = 2,
    localparam int AW        = clogb2(PAGE_DEPTH),
    localparam int PW        = clogb2(NPAGES),
    localparam int NW        = AW + 1
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic                 wr_en,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic                 wr_commit,
    output logic [PW-1:0]        wr_page,
    output logic                 wr_stall,
    input  logic                 rd_en,
    input  logic [PW-1:0]        rd_page,
    input  logic [AW-1:0]        rd_addr,
    input  logic                 rd_release,
    output logic [RAM_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic [NPAGES-1:0]    page_valid,
    output logic [NPAGES*NW-1:0] nent
`ifdef PAGED_MEM_OVFL_EN
    ,
    output logic [NPAGES-1:0]    wr_ovfl
`endif
);

    wr_state_t         state, state_next;
    logic [NW-1:0]     cnt, cnt_next;
    logic [NW-1:0]     nent_q [NPAGES];
    logic [NPAGES-1:0] valid_q, valid_after_rel;
    logic [PW-1:0]     next_page;
    logic              fill, accept, commit, release_ok, req, rzero;

    assign fill       = (state == FILL);
    assign accept     = fill && wr_en && (cnt != NW'(PAGE_DEPTH));
    assign commit     = fill && wr_commit;
    assign release_ok = rd_release && valid_q[rd_page];
    assign cnt_next   = cnt + NW'(accept);
    assign next_page  = wr_page + PW'(1);
    // Stall decisions look at ownership after this cycle's release, so a same-cycle release costs no bubble.
    assign valid_after_rel = valid_q & ~(release_ok ? (NPAGES'(1) << rd_page) : '0);

    always_ff @(posedge clka) begin
        if (rstb) state <= FILL;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:      if (commit && valid_after_rel[next_page]) state_next = WAIT_FREE;
            WAIT_FREE: if (!valid_after_rel[wr_page])            state_next = FILL;
            default:   state_next = FILL;
        endcase
    end

    assign wr_stall = (state == WAIT_FREE);

    always_ff @(posedge clka) begin
        if (rstb) begin
            wr_page <= '0;
            cnt     <= '0;
            valid_q <= '0;
            for (int p = 0; p < NPAGES; p++) nent_q[p] <= '0;
        end else begin
            if (commit) begin
                wr_page <= next_page;
                cnt     <= '0;
            end else begin
                cnt <= cnt_next;
            end
            for (int p = 0; p < NPAGES; p++) begin
                if (release_ok && (rd_page == PW'(p))) begin
                    valid_q[p] <= 1'b0;
                    nent_q[p]  <= '0;
                end
                if (commit && (wr_page == PW'(p))) begin
                    valid_q[p] <= 1'b1;
                    nent_q[p]  <= cnt_next;
                end
            end
        end
    end

`ifdef PAGED_MEM_OVFL_EN
    logic [NPAGES-1:0] ovfl_q;

    always_ff @(posedge clka) begin
        if (rstb) begin
            ovfl_q <= '0;
        end else begin
            for (int p = 0; p < NPAGES; p++) begin
                if (release_ok && (rd_page == PW'(p)))
                    ovfl_q[p] <= 1'b0;
                if (fill && wr_en && (cnt == NW'(PAGE_DEPTH)) && (wr_page == PW'(p)))
                    ovfl_q[p] <= 1'b1;
            end
        end
    end
    assign wr_ovfl = ovfl_q;
`endif

    assign page_valid = valid_q;

    generate
        for (genvar p = 0; p < NPAGES; p++) begin : g_nent
            assign nent[slice_lo(p, NW) +: NW] = nent_q[p];
        end
    endgenerate

    // Read request is qualified by ownership sampled before any same-cycle release.
    assign req   = rd_en && valid_q[rd_page];
    assign rzero = ({1'b0, rd_addr} >= nent_q[rd_page]);

    logic vld_p1;

    always_ff @(posedge clka) begin
        if (rstb) vld_p1 <= 1'b0;
        else      vld_p1 <= req;
    end

    generate
        if (RD_LATENCY == 2) begin : g_vld2
            logic vld_p2;
            always_ff @(posedge clka) begin
                if (rstb) vld_p2 <= 1'b0;
                else      vld_p2 <= vld_p1;
            end
            assign rd_valid = vld_p2;
        end else begin : g_vld1
            assign rd_valid = vld_p1;
        end
    endgenerate

    paged_mem_bram #(
        .RAM_WIDTH (RAM_WIDTH),
        .DEPTH     (NPAGES * PAGE_DEPTH),
        .RD_LATENCY(RD_LATENCY)
    ) u_bram (
        .clka (clka),
        .rstb (rstb),
        .we   (accept),
        .waddr({wr_page, cnt[AW-1:0]}),
        .wdata(wr_data),
        .re   (req),
        .rzero(rzero),
        .raddr({rd_page, rd_addr}),
        .dout (rd_data)
    );

endmodule
